// File: rtl/dunit_controller_pkg.sv
// Shared definitions for the debug-unit controller: host opcodes, FSM encodings
// and the register-file dump length.
package dunit_controller_pkg;

  localparam logic [2:0] OP_CLEAR     = 3'd0;
  localparam logic [2:0] OP_LOAD      = 3'd1;
  localparam logic [2:0] OP_RUN       = 3'd2;
  localparam logic [2:0] OP_STEP      = 3'd3;
  localparam logic [2:0] OP_DUMP_REG  = 3'd4;
  localparam logic [2:0] OP_DUMP_MEM  = 3'd5;

  localparam int unsigned REG_COUNT = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_STEP,
    ST_DREG,
    ST_DMEM
  } state_t;

  typedef enum logic [1:0] {
    RB_IDLE,
    RB_ADDR,
    RB_WAIT,
    RB_HOLD
  } rb_state_t;

endpackage

// File: rtl/dunit_controller_readback.sv
// Readback sequencer: walks addresses 0..count-1 against a one-cycle-latency
// read port and streams each word out with a valid/ready hold register.
module dunit_readback_seq
  import dunit_controller_pkg::*;
#(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_CNT  = 9
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_CNT-1:0]  i_count,
  input  logic [NB_DATA-1:0] i_rdata,
  input  logic               i_rsp_ready,
  output logic [NB_CNT-1:0]  o_addr,
  output logic               o_rsp_valid,
  output logic [NB_DATA-1:0] o_rsp_data,
  output logic               o_done
);

  rb_state_t          r_state;
  logic [NB_CNT-1:0]  r_addr;
  logic [NB_CNT-1:0]  r_last;
  logic               r_valid;
  logic [NB_DATA-1:0] r_data;
  logic               w_last_hs;

  // Final handshake of the walk; the parent leaves its dump state on it.
  always_comb begin
    w_last_hs = (r_state == RB_HOLD) && i_rsp_ready && (r_addr == r_last);
  end

  // Address present one cycle, capture the read data the next, then hold it
  // on the stream until the consumer takes it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RB_IDLE;
      r_addr  <= '0;
      r_last  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      case (r_state)
        RB_IDLE: begin
          if (i_start) begin
            r_addr  <= '0;
            r_last  <= i_count - NB_CNT'(1);
            r_state <= RB_ADDR;
          end
        end
        RB_ADDR: r_state <= RB_WAIT;
        RB_WAIT: begin
          r_data  <= i_rdata;
          r_valid <= 1'b1;
          r_state <= RB_HOLD;
        end
        RB_HOLD: begin
          if (i_rsp_ready) begin
            r_valid <= 1'b0;
            if (r_addr == r_last) begin
              r_addr  <= '0;
              r_state <= RB_IDLE;
            end else begin
              r_addr  <= r_addr + NB_CNT'(1);
              r_state <= RB_ADDR;
            end
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_state <= RB_IDLE;
        end
      endcase
    end
  end

  assign o_addr      = r_addr;
  assign o_rsp_valid = r_valid;
  assign o_rsp_data  = r_data;
  assign o_done      = w_last_hs;

endmodule

// File: rtl/dunit_controller.sv
// Debug-unit controller: accepts host commands to load instruction memory,
// run/step the pipeline, and dump the register file or data memory.
module dunit_controller
  import dunit_controller_pkg::*;
#(
  parameter int unsigned NB_REG   = 32,
  parameter int unsigned NB_WIDHT = 9,
  parameter int unsigned NB_ADDR  = 5
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [2:0]          i_cmd_op,
  input  logic [NB_REG-1:0]   i_cmd_data,
  input  logic                i_halt,
  input  logic [NB_REG-1:0]   i_dunit_reg,
  input  logic [NB_REG-1:0]   i_dunit_mem_data,
  output logic                o_dunit_clk_en,
  output logic                o_dunit_reset_pc,
  output logic                o_dunit_w_mem,
  output logic [NB_REG-1:0]   o_dunit_mem_addr,
  output logic [NB_REG-1:0]   o_dunit_data_if,
  output logic [NB_ADDR-1:0]  o_dunit_addr,
  output logic [NB_WIDHT-1:0] o_dunit_addr_data,
  output logic                o_rsp_valid,
  input  logic                i_rsp_ready,
  output logic [NB_REG-1:0]   o_rsp_data,
  output logic                o_halted,
  output logic                o_cmd_err,
  output logic [NB_REG-1:0]   o_cycle_cnt
);

  state_t              r_state;
  logic                r_cmd_ready;
  logic                r_clk_en;
  logic                r_reset_pc;
  logic                r_w_mem;
  logic                r_halted;
  logic                r_cmd_err;
  logic [NB_REG-1:0]   r_ptr;
  logic [NB_REG-1:0]   r_mem_addr;
  logic [NB_REG-1:0]   r_data_if;
  logic [NB_REG-1:0]   r_cycle_cnt;

  logic                w_accept;
  logic                w_clk_en;
  logic                w_rb_start;
  logic                w_rb_done;
  logic [NB_WIDHT-1:0] w_dmem_n;
  logic [NB_WIDHT-1:0] w_rb_count;
  logic [NB_WIDHT-1:0] w_rb_addr;
  logic [NB_REG-1:0]   w_rb_rdata;

  // Command decode and pipeline enable. In RUN the enable is masked by i_halt
  // in the same cycle so the halting cycle itself is never clocked.
  always_comb begin
    w_accept   = i_cmd_valid && r_cmd_ready;
    w_dmem_n   = i_cmd_data[NB_WIDHT-1:0];
    w_rb_start = w_accept && ((i_cmd_op == OP_DUMP_REG) ||
                              ((i_cmd_op == OP_DUMP_MEM) && (w_dmem_n != '0)));
    w_rb_count = (i_cmd_op == OP_DUMP_MEM) ? w_dmem_n : NB_WIDHT'(REG_COUNT);
    w_rb_rdata = (r_state == ST_DMEM) ? i_dunit_mem_data : i_dunit_reg;
    w_clk_en   = r_clk_en && !((r_state == ST_RUN) && i_halt);
  end

  // Main FSM with registered outputs, load pointer and cycle counter.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_clk_en    <= 1'b0;
      r_reset_pc  <= 1'b0;
      r_w_mem     <= 1'b0;
      r_halted    <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_ptr       <= '0;
      r_mem_addr  <= '0;
      r_data_if   <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_reset_pc <= 1'b0;
      r_w_mem    <= 1'b0;
      r_cmd_err  <= 1'b0;
      if (w_clk_en && (r_cycle_cnt != '1)) begin
        r_cycle_cnt <= r_cycle_cnt + NB_REG'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            case (i_cmd_op)
              OP_CLEAR: begin
                r_ptr       <= '0;
                r_halted    <= 1'b0;
                r_cycle_cnt <= '0;
                r_reset_pc  <= 1'b1;
              end
              OP_LOAD: begin
                r_state     <= ST_LOAD;
                r_cmd_ready <= 1'b0;
                r_w_mem     <= 1'b1;
                r_reset_pc  <= 1'b1;
                r_mem_addr  <= r_ptr;
                r_data_if   <= i_cmd_data;
                r_ptr       <= r_ptr + NB_REG'(4);
              end
              OP_RUN: begin
                if (r_halted) begin
                  r_cmd_err <= 1'b1;
                end else begin
                  r_state     <= ST_RUN;
                  r_cmd_ready <= 1'b0;
                  r_clk_en    <= 1'b1;
                end
              end
              OP_STEP: begin
                if (r_halted) begin
                  r_cmd_err <= 1'b1;
                end else begin
                  r_state     <= ST_STEP;
                  r_cmd_ready <= 1'b0;
                  r_clk_en    <= 1'b1;
                end
              end
              OP_DUMP_REG: begin
                r_state     <= ST_DREG;
                r_cmd_ready <= 1'b0;
              end
              OP_DUMP_MEM: begin
                if (w_dmem_n != '0) begin
                  r_state     <= ST_DMEM;
                  r_cmd_ready <= 1'b0;
                end
              end
              default: r_cmd_err <= 1'b1;
            endcase
          end
        end
        ST_LOAD: begin
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
        ST_RUN: begin
          if (i_halt) begin
            r_clk_en    <= 1'b0;
            r_halted    <= 1'b1;
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
          end
        end
        ST_STEP: begin
          if (i_halt) begin
            r_halted <= 1'b1;
          end
          r_clk_en    <= 1'b0;
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
        ST_DREG, ST_DMEM: begin
          if (w_rb_done) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
          end
        end
        default: begin
          r_clk_en    <= 1'b0;
          r_state     <= ST_IDLE;
          r_cmd_ready <= 1'b1;
        end
      endcase
    end
  end

  dunit_readback_seq #(
    .NB_DATA (NB_REG),
    .NB_CNT  (NB_WIDHT)
  ) u_readback (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_start     (w_rb_start),
    .i_count     (w_rb_count),
    .i_rdata     (w_rb_rdata),
    .i_rsp_ready (i_rsp_ready),
    .o_addr      (w_rb_addr),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_done      (w_rb_done)
  );

  assign o_cmd_ready       = r_cmd_ready;
  assign o_dunit_clk_en    = w_clk_en;
  assign o_dunit_reset_pc  = r_reset_pc;
  assign o_dunit_w_mem     = r_w_mem;
  assign o_dunit_mem_addr  = r_mem_addr;
  assign o_dunit_data_if   = r_data_if;
  assign o_dunit_addr      = w_rb_addr[NB_ADDR-1:0];
  assign o_dunit_addr_data = w_rb_addr;
  assign o_halted          = r_halted;
  assign o_cmd_err         = r_cmd_err;
  assign o_cycle_cnt       = r_cycle_cnt;

endmodule

// File: tb/tb_dunit_controller.sv
// Directed bench for dunit_controller: a command vector table plus
// hand-written sequences for run/halt, dumps and mid-operation reset.
module tb_dunit_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        halt;
  logic [31:0] dunit_reg;
  logic [31:0] dunit_mem;
  logic        clk_en, reset_pc, w_mem;
  logic [31:0] mem_addr, data_if;
  logic [4:0]  addr_r;
  logic [8:0]  addr_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        halted, cmd_err;
  logic [31:0] cycle_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dunit_controller #(.NB_REG(32), .NB_WIDHT(9), .NB_ADDR(5)) dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_cmd_valid       (cmd_valid),
    .o_cmd_ready       (cmd_ready),
    .i_cmd_op          (cmd_op),
    .i_cmd_data        (cmd_data),
    .i_halt            (halt),
    .i_dunit_reg       (dunit_reg),
    .i_dunit_mem_data  (dunit_mem),
    .o_dunit_clk_en    (clk_en),
    .o_dunit_reset_pc  (reset_pc),
    .o_dunit_w_mem     (w_mem),
    .o_dunit_mem_addr  (mem_addr),
    .o_dunit_data_if   (data_if),
    .o_dunit_addr      (addr_r),
    .o_dunit_addr_data (addr_d),
    .o_rsp_valid       (rsp_valid),
    .i_rsp_ready       (rsp_ready),
    .o_rsp_data        (rsp_data),
    .o_halted          (halted),
    .o_cmd_err         (cmd_err),
    .o_cycle_cnt       (cycle_cnt)
  );

  // Synchronous-read register file and data memory models.
  always @(posedge clk) begin
    dunit_reg <= 32'(addr_r) * 32'd3;
    dunit_mem <= 32'(addr_d) + 32'd100;
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  // Present a command for one edge; returns #1 into cycle T+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Collect a dump stream with rsp_ready toggling every other cycle.
  task automatic collect(input int n_exp, input bit is_mem, input string tag);
    int          idx      = 0;
    int          cyc      = 0;
    int          unstable = 0;
    logic        held_v   = 1'b0;
    logic [31:0] held_d   = '0;
    logic [31:0] exp;
    while (idx < n_exp && cyc < 600) begin
      @(negedge clk);
      rsp_ready = (cyc % 2) == 1;
      #1;
      if (held_v && rsp_valid && (rsp_data !== held_d)) unstable++;
      held_v = rsp_valid && !rsp_ready;
      held_d = rsp_data;
      if (rsp_valid && rsp_ready) begin
        exp = is_mem ? (32'(idx) + 32'd100) : (32'(idx) * 32'd3);
        chk32({tag, "_word"}, rsp_data, exp);
        idx++;
      end
      cyc++;
    end
    chk32({tag, "_count"}, 32'(idx), 32'(n_exp));
    chk32({tag, "_stable"}, 32'(unstable), 32'd0);
    next_cycle();
    rsp_ready = 1'b0;
    chk1({tag, "_ready_after"}, cmd_ready, 1'b1);
    chk1({tag, "_valid_after"}, rsp_valid, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] data;
    logic        e_ready;
    logic        e_wmem;
    logic        e_rpc;
    logic        e_clk;
    logic        e_err;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int  n;
    bit  done;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    halt = 1'b0; rsp_ready = 1'b0;

    tbl[0] = '{3'd0, 32'h0,        1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{3'd1, 32'h20010001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h20010001};
    tbl[2] = '{3'd1, 32'hAC010004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h4, 32'hAC010004};
    tbl[3] = '{3'd6, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    tbl[4] = '{3'd7, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};
    tbl[5] = '{3'd3, 32'h0,        1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
    tbl[6] = '{3'd5, 32'h0,        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_ready", cmd_ready, 1'b1);
    chk1("rst_clk_en", clk_en, 1'b0);
    chk1("rst_w_mem", w_mem, 1'b0);
    chk1("rst_reset_pc", reset_pc, 1'b0);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk32("rst_cycle_cnt", cycle_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Command table
    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].data);
      chk1($sformatf("v%0d_ready", i), cmd_ready, tbl[i].e_ready);
      chk1($sformatf("v%0d_wmem", i), w_mem, tbl[i].e_wmem);
      chk1($sformatf("v%0d_rpc", i), reset_pc, tbl[i].e_rpc);
      chk1($sformatf("v%0d_clk_en", i), clk_en, tbl[i].e_clk);
      chk1($sformatf("v%0d_err", i), cmd_err, tbl[i].e_err);
      chk1($sformatf("v%0d_rsp_valid", i), rsp_valid, 1'b0);
      if (tbl[i].e_wmem) begin
        chk32($sformatf("v%0d_addr", i), mem_addr, tbl[i].e_addr);
        chk32($sformatf("v%0d_wdata", i), data_if, tbl[i].e_wdata);
      end
      next_cycle();
      chk1($sformatf("v%0d_ready_t2", i), cmd_ready, 1'b1);
      chk1($sformatf("v%0d_clk_en_t2", i), clk_en, 1'b0);
      chk1($sformatf("v%0d_wmem_t2", i), w_mem, 1'b0);
      chk1($sformatf("v%0d_rpc_t2", i), reset_pc, 1'b0);
      chk1($sformatf("v%0d_err_t2", i), cmd_err, 1'b0);
    end
    chk32("tbl_cycle_cnt", cycle_cnt, 32'd1);
    chk1("tbl_halted", halted, 1'b0);

    // Halt in IDLE is ignored
    issue(3'd0, 32'h0);
    halt = 1'b1;
    next_cycle();
    next_cycle();
    halt = 1'b0;
    chk1("idle_halt_ignored", halted, 1'b0);
    chk32("clear_cnt", cycle_cnt, 32'd0);

    // RUN with halt on the 7th would-be enabled cycle
    issue(3'd2, 32'h0);
    n = 0;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      halt = (n == 6);
      #1;
      if (clk_en) n++;
      if (halt) done = 1'b1;
      next_cycle();
    end
    halt = 1'b0;
    chk1("run_halt_seen", done, 1'b1);
    chk32("run_en_cycles", 32'(n), 32'd6);
    chk1("run_halted", halted, 1'b1);
    chk32("run_cycle_cnt", cycle_cnt, 32'd6);
    chk1("run_ready", cmd_ready, 1'b1);
    chk1("run_clk_en_off", clk_en, 1'b0);

    // STEP while halted -> error pulse, no activity
    issue(3'd3, 32'h0);
    chk1("halted_step_clk_en", clk_en, 1'b0);
    chk1("halted_step_err", cmd_err, 1'b1);
    chk1("halted_step_ready", cmd_ready, 1'b1);
    next_cycle();
    chk1("halted_step_err_t2", cmd_err, 1'b0);
    chk32("halted_step_cnt", cycle_cnt, 32'd6);

    // CLEAR then STEP -> one enabled cycle
    issue(3'd0, 32'h0);
    chk1("clear_halted", halted, 1'b0);
    issue(3'd3, 32'h0);
    chk1("step_clk_en", clk_en, 1'b1);
    next_cycle();
    chk1("step_clk_en_t2", clk_en, 1'b0);
    chk32("step_cnt", cycle_cnt, 32'd1);

    // STEP with halt reported in the stepped cycle
    issue(3'd3, 32'h0);
    halt = 1'b1;
    next_cycle();
    halt = 1'b0;
    chk1("step_halt_halted", halted, 1'b1);
    chk32("step_halt_cnt", cycle_cnt, 32'd2);
    issue(3'd0, 32'h0);

    // Register dump and memory dumps
    issue(3'd4, 32'h0);
    chk1("dreg_ready_low", cmd_ready, 1'b0);
    collect(32, 1'b0, "dreg");
    issue(3'd5, 32'd3);
    collect(3, 1'b1, "dmem3");

    // Reset in the middle of RUN
    issue(3'd2, 32'h0);
    next_cycle();
    next_cycle();
    chk1("midrun_clk_en", clk_en, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    chk1("midrun_rst_clk_en", clk_en, 1'b0);
    chk1("midrun_rst_ready", cmd_ready, 1'b1);
    chk1("midrun_rst_valid", rsp_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Reset in the middle of a register dump with the response stalled
    issue(3'd4, 32'h0);
    repeat (4) next_cycle();
    chk1("middreg_valid", rsp_valid, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    chk1("middreg_rst_valid", rsp_valid, 1'b0);
    chk1("middreg_rst_ready", cmd_ready, 1'b1);
    chk1("middreg_rst_clk_en", clk_en, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dunit_controller.md
DUNIT_CONTROLLER -- requirements
Module: dunit_controller

Interface
REQ-001 Parameter NB_REG, default 32, datapath/instruction word width.
REQ-002 Parameter NB_WIDHT, default 9, data-memory word address width.
REQ-003 Parameter NB_ADDR, default 5, register-file address width.
REQ-004 One clock; reset is synchronous and active-high: i_clk input 1 rising-edge clock; i_reset input 1 synchronous active-high reset.
REQ-005 i_cmd_valid  input  1  host command present.
REQ-006 o_cmd_ready  output  1  command accepted when valid&ready.
REQ-007 i_cmd_op  input  3  0 CLEAR, 1 LOAD, 2 RUN, 3 STEP, 4 DUMP_REG, 5 DUMP_MEM, 6-7 illegal.
REQ-008 i_cmd_data  input  NB_REG  LOAD: instruction word; DUMP_MEM: word count in [NB_WIDHT-1:0].
REQ-009 i_halt  input  1  pipeline reports halt instruction retired.
REQ-010 i_dunit_reg / i_dunit_mem_data  input  NB_REG each  register / data-memory read data, valid one cycle after address.
REQ-011 o_dunit_clk_en, o_dunit_reset_pc, o_dunit_w_mem  output  1 each  pipeline step enable, PC reset, instruction-memory write.
REQ-012 o_dunit_mem_addr, o_dunit_data_if  output  NB_REG each  instruction-memory byte address and write word.
REQ-013 o_dunit_addr  output  NB_ADDR; o_dunit_addr_data  output  NB_WIDHT  readback addresses.
REQ-014 o_rsp_valid output 1, i_rsp_ready input 1, o_rsp_data output NB_REG  readback stream.
REQ-015 o_halted, o_cmd_err  output  1 each; o_cycle_cnt  output  NB_REG  enabled pipeline cycles.

Function
REQ-016 States IDLE, LOAD, RUN, STEP, DREG, DMEM; o_cmd_ready SHALL be 1 only in IDLE.
REQ-017 CLEAR accepted at T: load pointer:=0, o_halted:=0, o_cycle_cnt:=0, o_dunit_reset_pc=1 during T+1 only; stays IDLE.
REQ-018 LOAD accepted at T: in T+1 o_dunit_w_mem=1, o_dunit_reset_pc=1, o_dunit_mem_addr=pointer, o_dunit_data_if=i_cmd_data; pointer+=4 (wraps modulo 2^NB_REG); IDLE at T+2.
REQ-019 RUN: o_dunit_clk_en=1 every cycle from T+1 until the cycle i_halt is sampled 1; that cycle clk_en=0, o_halted:=1, return IDLE.
REQ-020 STEP: o_dunit_clk_en=1 for exactly cycle T+1; i_halt sampled then sets o_halted; IDLE at T+2.
REQ-021 o_cycle_cnt SHALL increment once per cycle with o_dunit_clk_en=1, saturating at all-ones.
REQ-022 RUN/STEP while o_halted=1, or op 6-7: command consumed, no pipeline activity, o_cmd_err pulses 1 cycle at T+1.
REQ-023 DREG: issue o_dunit_addr 0..31 in order; each word presented on o_rsp_data with o_rsp_valid held until i_rsp_ready; address advances only after handshake; IDLE after word 31 handshake.
REQ-024 DMEM: count N=i_cmd_data[NB_WIDHT-1:0]; addresses 0..N-1 on o_dunit_addr_data, same handshake as DREG; N=0 returns IDLE at T+1 with no response.
REQ-025 o_rsp_data SHALL stay stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-026 o_dunit_clk_en SHALL be 0 in every state except RUN/STEP; o_dunit_w_mem 0 except LOAD.
REQ-027 i_halt during DREG/DMEM/IDLE SHALL be ignored.

Reset
REQ-028 i_reset at any edge, including mid-RUN or mid-dump, SHALL force IDLE next cycle and drop o_rsp_valid.
REQ-029 Reset values: all outputs 0 except o_cmd_ready=1; load pointer 0; o_cycle_cnt 0; o_halted 0.

Structure
REQ-030 Shared package holds command opcode constants, state encoding, and REG_COUNT=32.
REQ-031 One sub-module natural: dunit_readback_seq (address counter plus valid/ready hold register) shared by DREG and DMEM.

Verification
REQ-032 LOAD 0x20010001 then 0xAC010004 -> w_mem pulses at addresses 0x0 and 0x4 with those words; o_cmd_ready low exactly one cycle each.
REQ-033 RUN with i_halt asserted at the 7th enabled cycle -> clk_en high exactly 6 cycles, o_halted=1, o_cycle_cnt=6.
REQ-034 STEP after halt -> no clk_en, o_cmd_err one-cycle pulse; CLEAR then STEP -> clk_en one cycle, o_cycle_cnt=1.
REQ-035 DREG with i_rsp_ready toggling every other cycle, i_dunit_reg=addr*3 -> 32 responses 0,3,...,93 in order, data stable while stalled.
REQ-036 DMEM count 0 -> no response, ready at T+1; count 3 -> three responses for addresses 0,1,2.
REQ-037 i_reset asserted mid-RUN and mid-DREG -> next cycle IDLE, clk_en=0, o_rsp_valid=0, o_cmd_ready=1.
